// File: rtl/anchor_controller.sv
// anchor_controller
//
// Initiator for the gradient stage. A 16-pixel-wide anchor window is walked
// down each vertical strip of the image. One 16-pixel row is fetched from
// image memory per step, held on gradient_in, and announced with a one-cycle
// anchor_moving pulse once the gradient stage reports gradient_final.
//
// Build option:
//   ANCHOR_PREFETCH_EN  defined   : MOVE goes straight to FETCH, so the next
//                                   row is read while the gradient stage is
//                                   still working on the current one.
//                       undefined : MOVE goes to DRAIN, and the next fetch
//                                   waits for gradient_final to reassert.
//
// Ports:
//   clk, n_rst       clock (rising edge), asynchronous active-low reset
//   start            one-cycle frame start, ignored while busy
//   base_addr        byte address of pixel (row 0, col 0), sampled on start
//   mem_read         read request, held until mem_ready
//   mem_addr         byte address of the requested 16-pixel row segment
//   mem_ready        read data valid this cycle (ignored outside FETCH)
//   mem_rdata        16 pixels, byte k is column anchor_y + k
//   gradient_in      row presented to the gradient stage
//   anchor_moving    one-cycle pulse: new row valid, anchor advanced
//   anchor_x         1-based row number within the current strip
//   anchor_y         starting column of the current strip
//   gradient_final   gradient stage idle or finished with its current row
//   busy             frame in progress
//   image_done       one-cycle pulse when the frame completes

module anchor_controller #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int STRIP_STEP = 14
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    output logic              mem_read,
    output logic [31:0]       mem_addr,
    input  logic              mem_ready,
    input  logic [127:0]      mem_rdata,
    output logic [15:0][7:0]  gradient_in,
    output logic              anchor_moving,
    output logic [31:0]       anchor_x,
    output logic [31:0]       anchor_y,
    input  logic              gradient_final,
    output logic              busy,
    output logic              image_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READY,
        S_MOVE,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic [31:0] LAST_ROW   = 32'(IMG_HEIGHT);
    localparam logic [31:0] LAST_STRIP = 32'(IMG_WIDTH - 16);
    localparam logic [31:0] ROW_PITCH  = 32'(IMG_WIDTH);
    localparam logic [31:0] STEP       = 32'(STRIP_STEP);

    state_t           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      row_q, row_d;          // 1-based row within the strip
    logic [31:0]      strip_q, strip_d;      // starting column of the strip
    logic [31:0]      row_base_q, row_base_d; // base + (row-1)*IMG_WIDTH, kept incrementally
    logic             guard_q, guard_d;      // high on the cycle right after MOVE
    logic [15:0][7:0] gradient_q, gradient_d;
    logic [31:0]      anchor_x_q, anchor_x_d;
    logic [31:0]      anchor_y_q, anchor_y_d;

    logic last_row;
    logic last_strip;

    assign last_row   = (row_q == LAST_ROW);
    assign last_strip = (strip_q == LAST_STRIP);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            row_q      <= '0;
            strip_q    <= '0;
            row_base_q <= '0;
            guard_q    <= 1'b0;
            // NOTE: the row buffer is reset too, because gradient_in must read
            // 0 the instant reset is applied, not merely hold stale pixels.
            gradient_q <= '0;
            anchor_x_q <= '0;
            anchor_y_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            base_q     <= base_d;
            row_q      <= row_d;
            strip_q    <= strip_d;
            row_base_q <= row_base_d;
            guard_q    <= guard_d;
            gradient_q <= gradient_d;
            anchor_x_q <= anchor_x_d;
            anchor_y_q <= anchor_y_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start)          state_d = S_FETCH;
            S_FETCH:  if (mem_ready)      state_d = S_READY;
            S_READY:  if (gradient_final) state_d = S_MOVE;
            S_MOVE: begin
                if (last_row && last_strip) begin
                    state_d = S_FINISH;
                end else begin
`ifdef ANCHOR_PREFETCH_EN
                    state_d = S_FETCH;
`else
                    state_d = S_DRAIN;
`endif
                end
            end
            // gradient_final is still high from the row just moved, so the
            // first cycle after MOVE is skipped before it is trusted again.
            S_DRAIN:  if (!guard_q && gradient_final) state_d = S_FETCH;
            S_FINISH: if (!guard_q && gradient_final) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        base_d     = base_q;
        row_d      = row_q;
        strip_d    = strip_q;
        row_base_d = row_base_q;
        gradient_d = gradient_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        guard_d    = (state_q == S_MOVE);

        if (state_q == S_IDLE && start) begin
            base_d     = base_addr;
            row_d      = 32'd1;
            strip_d    = '0;
            row_base_d = base_addr;
        end

        if (state_q == S_FETCH && mem_ready) begin
            gradient_d = mem_rdata;
        end

        // Load the anchor outputs on the READY->MOVE edge so they show the
        // position during MOVE and hold it until the next MOVE.
        if (state_q == S_READY && gradient_final) begin
            anchor_x_d = row_q;
            anchor_y_d = strip_q;
        end

        if (state_q == S_MOVE) begin
            if (row_q < LAST_ROW) begin
                row_d      = row_q + 32'd1;
                row_base_d = row_base_q + ROW_PITCH;
            end else begin
                row_d      = 32'd1;
                row_base_d = base_q;
                // The final strip is clamped flush with the right edge; its
                // columns overlap the previous strip and are simply refetched.
                strip_d    = (strip_q + STEP > LAST_STRIP) ? LAST_STRIP
                                                           : strip_q + STEP;
            end
        end
    end

    // Outputs.
    always_comb begin
        mem_read      = (state_q == S_FETCH);
        mem_addr      = (state_q == S_FETCH) ? row_base_q + strip_q : '0;
        anchor_moving = (state_q == S_MOVE);
        busy          = (state_q != S_IDLE);
        image_done    = (state_q == S_FINISH) && !guard_q && gradient_final;
        gradient_in   = gradient_q;
        anchor_x      = anchor_x_q;
        anchor_y      = anchor_y_q;
    end

endmodule

// File: tb/tb_anchor_controller.sv
// Self-checking bench for anchor_controller (IMG_WIDTH=32, IMG_HEIGHT=4).
// The expected walk is a hand-written table; expected moves and memory
// addresses are queued when a frame is started and popped by a monitor as
// the controller produces them.

module tb_anchor_controller;

    localparam int          W    = 32;
    localparam int          H    = 4;
    localparam int          STEP = 14;
    localparam logic [31:0] BASE = 32'h1000;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       base_addr = '0;
    logic              mem_read;
    logic [31:0]       mem_addr;
    logic              mem_ready = 1'b0;
    logic [127:0]      mem_rdata = '0;
    logic [15:0][7:0]  gradient_in;
    logic              anchor_moving;
    logic [31:0]       anchor_x;
    logic [31:0]       anchor_y;
    logic              gradient_final = 1'b1;
    logic              busy;
    logic              image_done;

    anchor_controller #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .STRIP_STEP(STEP)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .base_addr     (base_addr),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .gradient_in   (gradient_in),
        .anchor_moving (anchor_moving),
        .anchor_x      (anchor_x),
        .anchor_y      (anchor_y),
        .gradient_final(gradient_final),
        .busy          (busy),
        .image_done    (image_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [31:0] x;
        logic [31:0] addr;
    } vec_t;

    vec_t        tbl[12];
    vec_t        exp_moves[$];
    logic [31:0] exp_addrs[$];

    int n_vec = 0;
    int n_err = 0;

    int mem_lat  = 1;
    bit inject   = 1'b0;
    int mem_cnt  = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Pixel pattern returned by the memory model for a given byte address.
    function automatic logic [127:0] mem_word(input logic [31:0] a);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            logic [31:0] t;
            t = a + 32'(k);
            w[8*k +: 8] = t[7:0] ^ a[12:5];
        end
        return w;
    endfunction

    // Memory responder: answers a request mem_lat cycles after it appears.
    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            if (!inject) begin
                if (!n_rst || !mem_read || mem_ready) begin
                    mem_ready = 1'b0;
                    mem_cnt   = 0;
                end else begin
                    mem_cnt++;
                    if (mem_cnt >= mem_lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_word(mem_addr);
                    end
                end
            end
        end
    end

`ifndef ANCHOR_PREFETCH_EN
    logic gf_edge = 1'b1;
    always @(posedge clk) gf_edge <= gradient_final;
`endif

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin : monitor
        vec_t         v;
        bit           prev_move;
        bit           prev_read;
        bit           cap_pending;
        bit           expect_move;
        int           req_cycles;
        logic [31:0]  req_addr;
        logic [127:0] cap_data;
        prev_move = 0; prev_read = 0; cap_pending = 0; expect_move = 0;
        req_cycles = 0; req_addr = '0; cap_data = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_move = 0; prev_read = 0; cap_pending = 0; expect_move = 0;
            end else begin
                if (expect_move) begin
                    check("capture-to-move latency", anchor_moving, 1'b1);
                    expect_move = 0;
                end
                if (cap_pending) begin
                    check("gradient_in after capture", gradient_in, cap_data);
                    cap_pending = 0;
                    if (gradient_final) expect_move = 1;
                end
                if (anchor_moving) begin
                    check("anchor_moving spacing", prev_move, 1'b0);
                    if (exp_moves.size() == 0) begin
                        fail_now($sformatf("unexpected anchor_moving y=%0d x=%0d", anchor_y, anchor_x));
                    end else begin
                        v = exp_moves.pop_front();
                        check("anchor_y", anchor_y, v.y);
                        check("anchor_x", anchor_x, v.x);
                        check("gradient_in at move", gradient_in, mem_word(v.addr));
                    end
                end
                if (mem_read) begin
                    if (!prev_read) begin
                        req_addr   = mem_addr;
                        req_cycles = 0;
`ifndef ANCHOR_PREFETCH_EN
                        check("fetch only after gradient_final", gf_edge, 1'b1);
`endif
                    end else begin
                        check("mem_addr held", mem_addr, req_addr);
                    end
                    req_cycles++;
                    if (mem_ready) begin
                        if (exp_addrs.size() == 0)
                            fail_now($sformatf("unexpected read of %0h", mem_addr));
                        else
                            check("mem_addr", mem_addr, exp_addrs.pop_front());
                        check("mem_read cycles", req_cycles, mem_lat);
                        cap_data    = mem_rdata;
                        cap_pending = 1;
                    end
                end
                if (image_done) done_cnt++;
                prev_move = anchor_moving;
                prev_read = mem_read;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " mem_read"},      mem_read, 1'b0);
        check({tag, " mem_addr"},      mem_addr, 32'd0);
        check({tag, " gradient_in"},   gradient_in, 128'd0);
        check({tag, " anchor_moving"}, anchor_moving, 1'b0);
        check({tag, " anchor_x"},      anchor_x, 32'd0);
        check({tag, " anchor_y"},      anchor_y, 32'd0);
        check({tag, " busy"},          busy, 1'b0);
        check({tag, " image_done"},    image_done, 1'b0);
    endtask

    task automatic start_frame();
        done_cnt  = 0;
        base_addr = BASE;
        foreach (tbl[i]) begin
            exp_moves.push_back(tbl[i]);
            exp_addrs.push_back(tbl[i].addr);
        end
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("start latency mem_read", mem_read, 1'b1);
        check("busy after start", busy, 1'b1);
        #1 start = 1'b0;
    endtask

    task automatic wait_moves(input int n);
        int seen = 0;
        for (int c = 0; c < 500 && seen < n; c++) begin
            @(negedge clk);
            if (anchor_moving) seen++;
        end
        if (seen < n) fail_now("timeout waiting for anchor_moving");
    endtask

    task automatic end_frame(input bit poke_start);
        bit got = 0;
        for (int c = 0; c < 1500 && !got; c++) begin
            @(negedge clk);
            if (image_done) got = 1;
        end
        if (!got) fail_now("timeout waiting for image_done");
        if (poke_start) begin
            // start on the image_done cycle must not launch a new frame
            #1 start = 1'b1;
            @(negedge clk);
            #1 start = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("busy after frame", busy, 1'b0);
        check("mem_read after frame", mem_read, 1'b0);
        check("image_done pulses", done_cnt, 1);
        check("moves left over", exp_moves.size(), 0);
        check("reads left over", exp_addrs.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] snap;
        int           mv;
        bit           hit;

        tbl[0]  = '{y: 32'd0,  x: 32'd1, addr: 32'h1000};
        tbl[1]  = '{y: 32'd0,  x: 32'd2, addr: 32'h1020};
        tbl[2]  = '{y: 32'd0,  x: 32'd3, addr: 32'h1040};
        tbl[3]  = '{y: 32'd0,  x: 32'd4, addr: 32'h1060};
        tbl[4]  = '{y: 32'd14, x: 32'd1, addr: 32'h100E};
        tbl[5]  = '{y: 32'd14, x: 32'd2, addr: 32'h102E};
        tbl[6]  = '{y: 32'd14, x: 32'd3, addr: 32'h104E};
        tbl[7]  = '{y: 32'd14, x: 32'd4, addr: 32'h106E};
        tbl[8]  = '{y: 32'd16, x: 32'd1, addr: 32'h1010};
        tbl[9]  = '{y: 32'd16, x: 32'd2, addr: 32'h1030};
        tbl[10] = '{y: 32'd16, x: 32'd3, addr: 32'h1050};
        tbl[11] = '{y: 32'd16, x: 32'd4, addr: 32'h1070};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 n_rst = 1'b1;

        // Full-frame walk, fast memory, gradient stage always ready;
        // start on the image_done cycle is ignored.
        start_frame();
        end_frame(1'b1);

        // Backpressure after the second move, with a start while busy.
        start_frame();
        wait_moves(2);
        #1 start = 1'b1;
        gradient_final = 1'b0;
        mv   = 0;
        snap = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) #1 start = 1'b0;
            if (anchor_moving) mv++;
            if (i == 10) snap = gradient_in;
        end
        check("backpressure moves", mv, 0);
        check("backpressure gradient_in stable", gradient_in, snap);
        check("backpressure mem_read idle", mem_read, 1'b0);
        check("backpressure busy", busy, 1'b1);
        check("backpressure anchor_x hold", anchor_x, tbl[1].x);
        check("backpressure anchor_y hold", anchor_y, tbl[1].y);
        #1 gradient_final = 1'b1;
        end_frame(1'b0);

        // Slow memory: every read waits 7 cycles.
        mem_lat = 7;
        start_frame();
        end_frame(1'b0);
        mem_lat = 1;

        // mem_ready pulse while waiting in READY is ignored.
        start_frame();
        wait_moves(1);
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (mem_read) hit = 1;
        end
        if (!hit) fail_now("timeout waiting for second fetch");
        #1 gradient_final = 1'b0;
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (!mem_read) hit = 1;
        end
        if (!hit) fail_now("timeout waiting for READY");
        snap = gradient_in;
        #1 inject = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        @(negedge clk);
        check("stray mem_ready gradient_in", gradient_in, snap);
        check("stray mem_ready mem_read", mem_read, 1'b0);
        #1 mem_ready = 1'b0;
        inject = 1'b0;
        gradient_final = 1'b1;
        end_frame(1'b0);

        // Reset while a slow read is outstanding, then a late mem_ready.
        mem_lat = 7;
        start_frame();
        @(negedge clk);
        check("mem_read before reset", mem_read, 1'b1);
        #1 n_rst = 1'b0;
        #1 check_all_zero("async reset");
        exp_moves.delete();
        exp_addrs.delete();
        @(negedge clk);
        #1 n_rst = 1'b1;
        #1 inject = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        @(negedge clk);
        check("late mem_ready mem_read", mem_read, 1'b0);
        check("late mem_ready gradient_in", gradient_in, 128'd0);
        check("late mem_ready busy", busy, 1'b0);
        #1 mem_ready = 1'b0;
        inject = 1'b0;
        mem_lat = 1;
        start_frame();
        end_frame(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/anchor_controller.md
# anchor_controller

Drives the gradient stage as its initiator. It walks a 16-pixel-wide anchor window down each vertical strip of the image and fetches one 16-pixel row per step from image memory. It presents each row on `gradient_in` and pulses `anchor_moving` only when the gradient stage reports `gradient_final`. It sits between the image memory port and the gradient controller, and signals frame completion upstream.

## Interface
Parameters:
- `IMG_WIDTH`, 640: pixels per row; must be ≥ 16.
- `IMG_HEIGHT`, 480: rows per image; must be ≥ 1.
- `STRIP_STEP`, 14: column advance between strips. Equals the gradient outputs per row.

Ports (one clock `clk`; reset `n_rst` is asynchronous, active-low):
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle frame start; ignored while `busy`.
- `base_addr`  in  32  byte address of pixel (row 0, col 0); sampled on accepted `start`.
- `mem_read`  out  1  read request; held until `mem_ready`.
- `mem_addr`  out  32  byte address of the first pixel of the requested row segment.
- `mem_ready`  in  1  read data valid this cycle.
- `mem_rdata`  in  128  16 pixels; byte k is column `anchor_y + k`.
- `gradient_in`  out  [15:0][7:0]  row presented to the gradient stage.
- `anchor_moving`  out  1  one-cycle pulse: new row valid, anchor advanced.
- `anchor_x`  out  32  1-based row number within the current strip.
- `anchor_y`  out  32  starting column of the current strip.
- `gradient_final`  in  1  gradient stage idle or finished its current row.
- `busy`  out  1  frame in progress.
- `image_done`  out  1  one-cycle pulse when the frame completes.

## Operation
- **States:** IDLE, FETCH, READY, MOVE, FINISH, plus DRAIN when `ANCHOR_PREFETCH_EN` is off.
- **IDLE:**
  - On `start`: latch `base_addr`, set row=1 and strip=0, set `busy`=1, go to FETCH.
- **FETCH:**
  - `mem_read`=1 and `mem_addr` = base + (row−1)·IMG_WIDTH + strip.
  - On `mem_ready`: capture `mem_rdata` into `gradient_in`, drop `mem_read`, go to READY.
- **READY:**
  - Wait for `gradient_final`=1, then go to MOVE.
- **MOVE** (exactly one cycle):
  - `anchor_moving`=1; `anchor_x`=row and `anchor_y`=strip are driven this cycle.
  - `gradient_in` holds stable through this cycle.
  - Then advance the position:
    - row<IMG_HEIGHT: row+1.
    - Otherwise row=1, and strip advances by STRIP_STEP, clamped to IMG_WIDTH−16 if it would exceed that.
  - If the row just moved was the last row of the last strip (strip = IMG_WIDTH−16), go to FINISH.
  - Otherwise go to FETCH (prefetch build) or DRAIN (non-prefetch build).
- **DRAIN:**
  - Skip one guard cycle, because `gradient_final` is still high during the MOVE cycle.
  - Then wait for `gradient_final`=1 and go to FETCH.
- **FINISH:**
  - Skip the same one guard cycle, then wait for `gradient_final`=1.
  - Pulse `image_done` for one cycle, clear `busy`, go to IDLE.
- **Strip coverage:** columns 0, 14, 28, … up to the clamped final strip. Overlapping columns are refetched, not skipped.
- **Arithmetic:** all 32-bit unsigned; overflow is undefined and not checked.

## Timing
- **Reset values:** every output is 0 (`mem_read`, `mem_addr`, `gradient_in`, `anchor_moving`, `anchor_x`, `anchor_y`, `busy`, `image_done`); state=IDLE.
- **Start latency:** `mem_read` rises the cycle after `start`.
- **Memory latency:** `gradient_in` updates on the edge where `mem_ready`=1. READY is entered on the same edge.
- **MOVE:** follows READY by one cycle once `gradient_final`=1. If `gradient_final` is already high on READY entry, latency from capture to `anchor_moving` is 1 cycle.
- **`anchor_moving` spacing:** never asserted on two consecutive cycles.
- **`anchor_x`/`anchor_y`:** hold their MOVE values until the next MOVE.
- **`mem_ready` outside FETCH:** ignored.
- **`start` during `busy`:** ignored.
- **`start` on the same cycle as `image_done`:** ignored.
- **Reset mid-frame:** everything returns to reset values immediately. An outstanding read is abandoned; a late `mem_ready` is ignored.

## Configuration
- `ANCHOR_PREFETCH_EN` defined:
  - MOVE goes directly to FETCH, so the next row is fetched while the gradient stage processes the current one.
  - MOVE-to-MOVE spacing is max(memory latency + 2, gradient processing time).
- Undefined:
  - MOVE goes to DRAIN, so the fetch starts only after `gradient_final` reasserts.
  - Fetches are fully serialized with processing.

## Test plan
1. **Full-frame walk:** IMG_WIDTH=32, IMG_HEIGHT=4, base=0x1000, `mem_ready` one cycle after each request, `gradient_final` tied 1.
   - Exactly 12 `anchor_moving` pulses with (`anchor_y`,`anchor_x`) = (0,1..4), (14,1..4), (16,1..4).
   - First `mem_addr`=0x1000; row-2 address 0x1020; last address 0x1000+3·32+16=0x1070.
   - `image_done` pulses once.
2. **Backpressure:** hold `gradient_final`=0 for 20 cycles after a MOVE.
   - No further `anchor_moving`; `gradient_in` stable; (prefetch build) `mem_read` completes during the wait.
3. **Slow memory:** `mem_ready` delayed 7 cycles.
   - `mem_read` and `mem_addr` held constant for 7 cycles; `gradient_in` equals `mem_rdata` from the `mem_ready` cycle.
4. **Ignored inputs:**
   - `start` while `busy` → no restart, sequence unchanged.
   - `mem_ready` pulse in READY → `gradient_in` unchanged.
5. **Reset mid-FETCH:** assert `n_rst`=0 with `mem_read`=1.
   - All outputs 0 asynchronously; after release, `start` begins again at (0,1).
6. **Build comparison:** same stimulus as scenario 1, built without `ANCHOR_PREFETCH_EN`.
   - Identical pulse and address sequence.
   - `mem_read` never asserted while `gradient_final`=0 after a MOVE.
